muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit and controller for the MIPS pipeline.
- Owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU one bit per cycle, plus MTHI/MTLO.
- Raises a stall request toward the hazard logic when a HI/LO read arrives while an operation is in flight.
- Sits beside the EX-stage ALU. The decode controller issues MdOp; the pipeline holds issue while Busy is high.

---
 rtl/muldiv_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MIPS multiply/divide unit owning HI/LO
`timescale 1ns/1ps
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       MdOp,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiLoRead,
  input  logic             Flush,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Stall
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 is_div_q, is_div_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divz_q, divz_d;

  logic                 is_start, is_signed, is_divop, sa, sb;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh, diff;
  logic                 qbit;
  logic [WIDTH-1:0]     new_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // Operand decode and one-bit-per-cycle multiply/divide datapath steps.
  always_comb begin
    is_start  = (MdOp == OP_MULT) || (MdOp == OP_MULTU) || (MdOp == OP_DIV) || (MdOp == OP_DIVU);
    is_signed = (MdOp == OP_MULT) || (MdOp == OP_DIV);
    is_divop  = (MdOp == OP_DIV) || (MdOp == OP_DIVU);
    sa        = is_signed & OpA[WIDTH-1];
    sb        = is_signed & OpB[WIDTH-1];
    abs_a     = sa ? (WIDTH'(0) - OpA) : OpA;
    abs_b     = sb ? (WIDTH'(0) - OpB) : OpB;

    // Shift-add: conditionally add multiplicand to the upper half, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder, trial-subtract.
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, b_q};
    qbit      = ~diff[WIDTH];
    new_rem   = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_next  = {new_rem, acc_q[WIDTH-2:0], qbit};

    prod_fix  = qneg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    quot_fix  = qneg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Controller: next state, iteration bookkeeping and HI/LO write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          if (is_start) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = is_divop;
            qneg_d   = sa ^ sb;
            rneg_d   = sa;
            dz_d     = is_divop && (OpB == '0);
            b_d      = abs_b;
            if (is_divop) begin
              // Keep the raw dividend: a divide by zero returns it untouched in HI.
              a_d   = OpA;
              acc_d = {{WIDTH{1'b0}}, abs_a};
            end else begin
              a_d   = abs_a;
              acc_d = {{WIDTH{1'b0}}, abs_b};
            end
          end else if (MdOp == OP_MTHI) begin
            hi_d = OpA;
          end else if (MdOp == OP_MTLO) begin
            lo_d = OpA;
          end
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!Flush) begin
          done_d = 1'b1;
          if (is_div_q && dz_q) begin
            hi_d   = a_q;
            lo_d   = '1;
            divz_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign DivZero = divz_q;
  assign Stall   = HiLoRead & Busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
`timescale 1ns/1ps
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [2:0]   MdOp;
  logic [W-1:0] OpA, OpB;
  logic         HiLoRead, Flush;
  logic [W-1:0] Hi, Lo;
  logic         Busy, Done, DivZero, Stall;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .MdOp(MdOp), .OpA(OpA), .OpB(OpB),
    .HiLoRead(HiLoRead), .Flush(Flush), .Hi(Hi), .Lo(Lo), .Busy(Busy),
    .Done(Done), .DivZero(DivZero), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for Done, check latency, result and pulse width.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dz);
    int busy_n;
    bit seen;
    @(negedge Clk); MdOp = op; OpA = a; OpB = b;
    @(negedge Clk); MdOp = 3'b000;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_n++;
      @(negedge Clk);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
    chk({tag, "_hi"}, Hi, exp_hi);
    chk({tag, "_lo"}, Lo, exp_lo);
    chk({tag, "_divzero"}, 32'(DivZero), 32'(exp_dz));
    chk({tag, "_busy_in_done"}, 32'(Busy), 32'd0);
    @(negedge Clk);
    chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    chk({tag, "_divzero_pulse"}, 32'(DivZero), 32'd0);
  endtask

  initial begin
    int stall_bad;
    bit seen_done;
    Rst_n = 1'b0; MdOp = 3'b000; OpA = '0; OpB = '0; HiLoRead = 1'b0; Flush = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_divzero", 32'(DivZero), 32'd0);
    Rst_n = 1'b1;

    run_op("mult_neg3x7", 3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_m1m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    run_op("div_m7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_by0", 3'b100, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    run_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("div_neg_by0", 3'b011, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    // Stall while busy, drop in the Done cycle; a second MULT mid-flight is ignored.
    @(negedge Clk); MdOp = 3'b001; OpA = 32'd5; OpB = 32'd6; HiLoRead = 1'b1;
    @(negedge Clk); MdOp = 3'b000;
    stall_bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (Stall !== 1'b1) stall_bad++;
      if (c == 10) begin MdOp = 3'b001; OpA = 32'd100; OpB = 32'd100; end
      if (c == 11) MdOp = 3'b000;
      @(negedge Clk);
    end
    chk("stall_cycles_1_33", 32'(stall_bad), 32'd0);
    chk("stall_done_cycle_done", 32'(Done), 32'd1);
    chk("stall_done_cycle_stall", 32'(Stall), 32'd0);
    chk("stall_result_hi", Hi, 32'd0);
    chk("stall_result_lo", Lo, 32'd30);
    @(negedge Clk); HiLoRead = 1'b0;
    chk("second_mult_not_started", 32'(Busy), 32'd0);

    // MTHI / MTLO: single-edge writes, never busy.
    MdOp = 3'b101; OpA = 32'h12345678;
    @(negedge Clk);
    chk("mthi_hi", Hi, 32'h12345678);
    chk("mthi_busy", 32'(Busy), 32'd0);
    MdOp = 3'b110; OpA = 32'h9ABCDEF0;
    @(negedge Clk);
    MdOp = 3'b000;
    chk("mtlo_lo", Lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", Hi, 32'h12345678);
    chk("mtlo_busy", 32'(Busy), 32'd0);

    // Flush in IDLE discards a same-cycle op.
    MdOp = 3'b001; OpA = 32'd3; OpB = 32'd3; Flush = 1'b1;
    @(negedge Clk); MdOp = 3'b000; Flush = 1'b0;
    chk("idle_flush_busy", 32'(Busy), 32'd0);

    // DIVU 10/3 flushed at cycle 5: aborts with no write and no Done.
    MdOp = 3'b100; OpA = 32'd10; OpB = 32'd3;
    @(negedge Clk); MdOp = 3'b000;
    repeat (4) @(negedge Clk);
    chk("flush_busy_before", 32'(Busy), 32'd1);
    Flush = 1'b1;
    @(negedge Clk); Flush = 1'b0;
    chk("flush_busy_after", 32'(Busy), 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (Done) seen_done = 1'b1;
      @(negedge Clk);
    end
    chk("flush_no_done", 32'(seen_done), 32'd0);
    chk("flush_hi_kept", Hi, 32'h12345678);
    chk("flush_lo_kept", Lo, 32'h9ABCDEF0);

    // Reset mid-divide clears everything; the next divide runs normally.
    MdOp = 3'b100; OpA = 32'd1000; OpB = 32'd7;
    @(negedge Clk); MdOp = 3'b000;
    repeat (11) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_hi", Hi, 32'h0);
    chk("midrst_lo", Lo, 32'h0);
    run_op("divu_1000_7", 3'b100, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
